// File: rtl/seven_seg_scanner.sv
// Four-digit seven-segment scan controller.
// Time-multiplexes digits with blanking, blink and decimal-point control.
module seven_seg_scanner #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 250
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] digits_in,
  input  logic [3:0]  blink_mask,
  input  logic [3:0]  dp_mask,
  input  logic        lz_en,
  output logic [1:0]  en,
  output logic [3:0]  num,
  output logic        blank,
  output logic        dp_n,
  output logic        scan_done
);

  localparam int PW =
    (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW =
    (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [PW-1:0] PRE_LAST =
    PW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BLK_LAST =
    BW'(BLINK_DIV - 1);

  logic [PW-1:0] pre;
  logic          tick;
  logic          scan_end;

  logic [BW-1:0] bcnt;
  logic          phase;
  logic          bwrap;
  logic          phase_nx;

  logic [15:0]   snap_d;
  logic [3:0]    snap_b;
  logic [3:0]    snap_dp;
  logic          snap_lz;

  logic [15:0]   src_d;
  logic [3:0]    src_b;
  logic [3:0]    src_dp;
  logic          src_lz;

  logic [1:0]    en_nx;
  logic [3:0]    slot_oh;
  logic [3:0]    lz_vec;
  logic [3:0]    num_nx;
  logic          blank_nx;
  logic          dp_nx;

  assign tick     = (pre == PRE_LAST);
  assign scan_end = tick && (en == 2'd3);
  assign bwrap    = tick && (bcnt == BLK_LAST);
  assign phase_nx = bwrap ? ~phase : phase;
  assign en_nx    = en + 2'd1;

  // Slot prescaler: one tick every REFRESH_DIV clocks.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre <= '0;
    end else if (tick) begin
      pre <= '0;
    end else begin
      pre <= pre + 1'b1;
    end
  end

  // Blink phase: toggles every BLINK_DIV slot ticks.
  always_ff @(posedge clk) begin
    if (rst) begin
      bcnt  <= '0;
      phase <= 1'b0;
    end else if (tick) begin
      if (bcnt == BLK_LAST) begin
        bcnt <= '0;
      end else begin
        bcnt <= bcnt + 1'b1;
      end
      phase <= phase_nx;
    end
  end

  // Snapshot all inputs once per scan so a scan never tears.
  always_ff @(posedge clk) begin
    if (rst) begin
      snap_d  <= '0;
      snap_b  <= '0;
      snap_dp <= '0;
      snap_lz <= 1'b0;
    end else if (scan_end) begin
      snap_d  <= digits_in;
      snap_b  <= blink_mask;
      snap_dp <= dp_mask;
      snap_lz <= lz_en;
    end
  end

  // Digit 0 of a new scan already sees the fresh snapshot.
  always_comb begin
    src_d  = snap_d;
    src_b  = snap_b;
    src_dp = snap_dp;
    src_lz = snap_lz;
    if (scan_end) begin
      src_d  = digits_in;
      src_b  = blink_mask;
      src_dp = dp_mask;
      src_lz = lz_en;
    end
  end

  // Leading-zero chain: a digit is dark only if it and all
  // higher digits are zero; digit 0 always shows.
  always_comb begin
    lz_vec    = '0;
    lz_vec[3] = src_lz && (src_d[15:12] == 4'd0);
    lz_vec[2] = lz_vec[3] && (src_d[11:8] == 4'd0);
    lz_vec[1] = lz_vec[2] && (src_d[7:4] == 4'd0);
    lz_vec[0] = 1'b0;
  end

  // Select value and attributes for the upcoming slot.
  always_comb begin
    slot_oh = 4'b0001 << en_nx;
    num_nx  = src_d[3:0];
    unique case (1'b1)
      slot_oh[0]: num_nx = src_d[3:0];
      slot_oh[1]: num_nx = src_d[7:4];
      slot_oh[2]: num_nx = src_d[11:8];
      slot_oh[3]: num_nx = src_d[15:12];
      default:    num_nx = src_d[3:0];
    endcase
    blank_nx = (src_b[en_nx] && phase_nx) || lz_vec[en_nx];
    dp_nx    = blank_nx ? 1'b1 : ~src_dp[en_nx];
  end

  // Registered decoder drive; updates only on slot ticks.
  always_ff @(posedge clk) begin
    if (rst) begin
      en    <= 2'd0;
      num   <= 4'd0;
      blank <= 1'b1;
      dp_n  <= 1'b1;
    end else if (tick) begin
      en    <= en_nx;
      num   <= num_nx;
      blank <= blank_nx;
      dp_n  <= dp_nx;
    end
  end

  // One-clock pulse as digit 3's slot closes.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_done <= 1'b0;
    end else begin
      scan_done <= scan_end;
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner.
// Directed and random stimulus against a slot/scan-level model.
module tb_seven_seg_scanner;

  localparam int RD = 4;
  localparam int BD = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] digits_in = '0;
  logic [3:0]  blink_mask = '0;
  logic [3:0]  dp_mask = '0;
  logic        lz_en = 1'b0;
  logic [1:0]  en;
  logic [3:0]  num;
  logic        blank;
  logic        dp_n;
  logic        scan_done;

  int checks = 0;
  int failures = 0;

  // model state
  int          cyc;
  int          k;
  logic [15:0] m_d;
  logic [3:0]  m_b;
  logic [3:0]  m_dp;
  logic        m_lz;
  logic [1:0]  e_en;
  logic [3:0]  e_num;
  logic        e_blank;
  logic        e_dp;
  logic        e_done;

  seven_seg_scanner #(
    .REFRESH_DIV(RD),
    .BLINK_DIV(BD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .digits_in(digits_in),
    .blink_mask(blink_mask),
    .dp_mask(dp_mask),
    .lz_en(lz_en),
    .en(en),
    .num(num),
    .blank(blank),
    .dp_n(dp_n),
    .scan_done(scan_done)
  );

  always #5 clk = ~clk;

  function automatic logic lz_dark(int i);
    if (!m_lz || i == 0) return 1'b0;
    for (int j = i; j < 4; j++) begin
      if (m_d[4*j +: 4] != 4'd0) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic chk(string tag, logic [3:0] obs,
                     logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d k=%0d obs=%0h exp=%0h",
             tag, cyc, k, obs, exp);
    end
  endtask

  task automatic step();
    int  i;
    logic ph;
    @(posedge clk);
    if (rst) begin
      cyc = 0; k = 0;
      m_d = '0; m_b = '0; m_dp = '0; m_lz = 1'b0;
      e_en = 2'd0; e_num = 4'd0;
      e_blank = 1'b1; e_dp = 1'b1; e_done = 1'b0;
    end else begin
      cyc++;
      e_done = 1'b0;
      if (cyc % RD == 0) begin
        k++;
        if (k % 4 == 0) begin
          m_d = digits_in; m_b = blink_mask;
          m_dp = dp_mask; m_lz = lz_en;
          e_done = 1'b1;
        end
        i = k % 4;
        ph = ((k / BD) % 2) == 1;
        e_en = 2'(i);
        e_num = m_d[4*i +: 4];
        e_blank = (m_b[i] && ph) || lz_dark(i);
        e_dp = e_blank ? 1'b1 : ~m_dp[i];
      end
    end
    #1;
    chk("en", {2'b0, en}, {2'b0, e_en});
    chk("num", num, e_num);
    chk("blank", {3'b0, blank}, {3'b0, e_blank});
    chk("dp_n", {3'b0, dp_n}, {3'b0, e_dp});
    chk("scan_done", {3'b0, scan_done}, {3'b0, e_done});
  endtask

  task automatic run(int n);
    for (int r = 0; r < n; r++) step();
  endtask

  task automatic wait_en(logic [1:0] want);
    int n = 0;
    while (e_en != want && n < 32) begin
      step();
      n++;
    end
    checks++;
    if (e_en != want) begin
      failures++;
      $error("FAIL wait_en obs=%0d exp=%0d", e_en, want);
    end
  endtask

  function automatic logic [15:0] rnd_digits();
    logic [15:0] v;
    for (int j = 0; j < 4; j++) begin
      v[4*j +: 4] = ($urandom_range(0, 1) == 0) ?
        4'd0 : 4'($urandom_range(0, 15));
    end
    return v;
  endfunction

  initial begin
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;

    digits_in = 16'h1234;
    run(40);

    wait_en(2'd1);
    digits_in = 16'h5678;
    run(36);

    digits_in = 16'h0050;
    lz_en = 1'b1;
    run(32);
    digits_in = 16'h0000;
    run(32);

    lz_en = 1'b0;
    digits_in = 16'h9821;
    blink_mask = 4'b0001;
    dp_mask = 4'b0100;
    run(64);

    for (int it = 0; it < 40; it++) begin
      digits_in = rnd_digits();
      blink_mask = 4'($urandom_range(0, 15));
      dp_mask = 4'($urandom_range(0, 15));
      lz_en = 1'($urandom_range(0, 1));
      run(int'($urandom_range(1, 12)));
    end

    digits_in = 16'h9abc;
    blink_mask = 4'b0000;
    dp_mask = 4'b0000;
    lz_en = 1'b0;
    run(20);
    wait_en(2'd2);
    run(1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    run(24);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
